// File: rtl/clause_queue.sv
// rtl/clause_queue.sv - per-engine FWFT clause FIFO between the clause arbiter and the BCP engine
module clause_queue #(
   parameter int CLAUSE_WIDTH    = 4,
   parameter int ELEMENT_BIT_CNT = 11,
   parameter int DEPTH           = 8,
   parameter int SKID            = 1
) (
   input  logic                                      clock,
   input  logic                                      reset,
   input  logic                                      push_in,
   input  logic [CLAUSE_WIDTH*ELEMENT_BIT_CNT-1:0]   clause_in,
   input  logic                                      pop_in,
   input  logic                                      flush_in,
   output logic [CLAUSE_WIDTH*ELEMENT_BIT_CNT-1:0]   clause_out,
   output logic                                      valid_out,
   output logic                                      full_out,
   output logic [$clog2(DEPTH):0]                    count_out,
   output logic                                      overflow_out
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = CLAUSE_WIDTH * ELEMENT_BIT_CNT;
   localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH - SKID);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic [AW:0]   count, count_nxt;
   logic          overflow, overflow_nxt;
   logic          is_empty, is_full, do_push, do_pop;

   // Decide effective push/pop and compute next pointer, count and sticky overflow.
   // Flush wins over push/pop; a full queue accepts a push only alongside a real pop.
   always_comb begin
      is_empty     = (count == '0);
      is_full      = (count == DEPTH_LVL);
      do_pop       = pop_in && !is_empty && !flush_in;
      do_push      = push_in && (!is_full || do_pop) && !flush_in;
      wr_ptr_nxt   = wr_ptr;
      rd_ptr_nxt   = rd_ptr;
      count_nxt    = count;
      overflow_nxt = overflow | (push_in && is_full && !do_pop && !flush_in);
      if (flush_in) begin
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
         count_nxt  = '0;
      end else begin
         if (do_push) wr_ptr_nxt = wr_ptr + AW'(1);
         if (do_pop)  rd_ptr_nxt = rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_nxt = count + (AW+1)'(1);
            2'b01:   count_nxt = count - (AW+1)'(1);
            default: count_nxt = count;
         endcase
      end
   end

   // Control state register; overflow survives flush and clears only on reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr_nxt;
         rd_ptr   <= rd_ptr_nxt;
         count    <= count_nxt;
         overflow <= overflow_nxt;
      end
   end

   // Entry storage; contents are don't-care after reset so no clear is needed.
   always_ff @(posedge clock) begin
      if (reset && do_push) mem[wr_ptr] <= clause_in;
   end

   // Outputs are derived from registered state only, so full_out has no path from push_in.
   assign valid_out    = !is_empty;
   assign count_out    = count;
   assign full_out     = (count >= FULL_LVL);
   assign overflow_out = overflow;
   assign clause_out   = valid_out ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_clause_queue.sv
// tb/tb_clause_queue.sv - directed scoreboard bench for clause_queue
module tb_clause_queue;

   localparam int DW = 44;

   logic          clock;
   logic          reset;
   logic          push_in;
   logic [DW-1:0] clause_in;
   logic          pop_in;
   logic          flush_in;
   logic [DW-1:0] clause_out;
   logic          valid_out;
   logic          full_out;
   logic [3:0]    count_out;
   logic          overflow_out;

   logic [DW-1:0] sb[$];
   logic          ovf_model;
   int            vectors;
   int            miscompares;

   clause_queue #(
      .CLAUSE_WIDTH(4), .ELEMENT_BIT_CNT(11), .DEPTH(8), .SKID(1)
   ) dut (
      .clock(clock), .reset(reset), .push_in(push_in), .clause_in(clause_in),
      .pop_in(pop_in), .flush_in(flush_in), .clause_out(clause_out),
      .valid_out(valid_out), .full_out(full_out), .count_out(count_out),
      .overflow_out(overflow_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [DW-1:0] pat(input int v);
      logic [10:0] l;
      l = 11'(v);
      return {l, l, l, l};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      int n;
      n = sb.size();
      check({tag, ".count"}, 64'(count_out), 64'(n));
      check({tag, ".valid"}, 64'(valid_out), 64'(n != 0));
      check({tag, ".full"},  64'(full_out),  64'(n >= 7));
      check({tag, ".ovf"},   64'(overflow_out), 64'(ovf_model));
      check({tag, ".head"},  64'(clause_out), (n != 0) ? 64'(sb[0]) : 64'd0);
   endtask

   // One clock: model the expected effect, apply inputs, then check 1 time unit after the edge.
   task automatic cycle(input string tag, input logic p, input logic [DW-1:0] d,
                        input logic q, input logic f);
      logic eff_pop, eff_push;
      if (q && sb.size() != 0 && !f)
         check({tag, ".popdata"}, 64'(clause_out), 64'(sb[0]));
      if (f) begin
         sb.delete();
      end else begin
         eff_pop  = q && (sb.size() != 0);
         eff_push = p && (sb.size() < 8 || eff_pop);
         if (p && !eff_push) ovf_model = 1'b1;
         if (eff_pop)  void'(sb.pop_front());
         if (eff_push) sb.push_back(d);
      end
      push_in = p; clause_in = d; pop_in = q; flush_in = f;
      @(posedge clock);
      #1;
      push_in = 1'b0; pop_in = 1'b0; flush_in = 1'b0; clause_in = '0;
      check_state(tag);
   endtask

   initial begin
      vectors = 0; miscompares = 0; ovf_model = 1'b0;
      push_in = 1'b0; pop_in = 1'b0; flush_in = 1'b0; clause_in = '0;
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check_state("reset");
      reset = 1'b1;
      @(posedge clock);
      #1;
      check_state("post_reset");

      // fill to the early-full threshold, then to DEPTH
      for (int i = 0; i < 7; i++) cycle("fill", 1'b1, pat(i), 1'b0, 1'b0);
      cycle("fill8", 1'b1, pat(7), 1'b0, 1'b0);

      // push at DEPTH without pop is dropped and sets overflow
      cycle("ovf_push", 1'b1, pat(12'h5A5), 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) cycle("drain", 1'b0, '0, 1'b1, 1'b0);

      // push+pop while full keeps count at DEPTH
      for (int i = 0; i < 8; i++) cycle("refill", 1'b1, pat(16 + i), 1'b0, 1'b0);
      cycle("full_pp", 1'b1, pat(99), 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) cycle("drain2", 1'b0, '0, 1'b1, 1'b0);

      // push+pop on empty: no bypass, entry visible next cycle
      cycle("empty_pp", 1'b1, pat(333), 1'b1, 1'b0);
      cycle("pop_one", 1'b0, '0, 1'b1, 1'b0);
      cycle("pop_empty", 1'b0, '0, 1'b1, 1'b0);

      // flush beats a same-cycle push
      for (int i = 0; i < 5; i++) cycle("pre_flush", 1'b1, pat(40 + i), 1'b0, 1'b0);
      cycle("flush", 1'b1, pat(777), 1'b1, 1'b1);

      // stream 20 clauses through for pointer wrap
      for (int i = 0; i < 20; i++)
         cycle("stream", 1'b1, pat(100 + i * 7) ^ 44'(i), (sb.size() >= 3), 1'b0);
      for (int i = 0; i < 8; i++) cycle("final_drain", 1'b0, '0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
